// File: rtl/rnn_mem_responder_pkg.sv
// Shared constants for the RNN memory responder: bank selects, default sizes, run FSM states.
package rnn_mem_pkg;
  localparam int H_DIM      = 64;
  localparam int X_DIM      = 32;
  localparam int DW         = 20;
  localparam int TW         = 11;
  localparam int FIFO_DEPTH = 4;

  localparam logic [2:0] MSEL_WIH = 3'b000;
  localparam logic [2:0] MSEL_BIH = 3'b001;
  localparam logic [2:0] MSEL_WHH = 3'b010;
  localparam logic [2:0] MSEL_BHH = 3'b011;
  localparam logic [2:0] MSEL_T   = 3'b100;
  localparam logic [2:0] MSEL_OUT = 3'b101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  typedef enum logic [1:0] {IDLE = ST_IDLE, ARMED = ST_ARMED, RUN = ST_RUN} run_state_t;
endpackage

// File: rtl/rnn_mem_responder_if.sv
// Core/host-facing bundle of the memory responder; slave = responder, master = core + host.
interface rnn_mem_responder_if #(
  parameter int DW    = 20,
  parameter int TW    = 11,
  parameter int X_DIM = 32
);
  logic             ready, busy, i_en;
  logic [X_DIM-1:0] idata;
  logic             mce;
  logic [2:0]       msel;
  logic [16:0]      maddr;
  logic [DW-1:0]    mdata_r, mdata_w;
  logic             ld_en;
  logic [2:0]       ld_sel;
  logic [11:0]      ld_addr;
  logic [DW-1:0]    ld_data;
  logic             start, x_valid, x_ready;
  logic [X_DIM-1:0] x_data;
  logic             o_valid, done;
  logic [TW-1:0]    o_t;
  logic [5:0]       o_h;
  logic [DW-1:0]    o_data;

  modport slave (
    input  busy, i_en, mce, msel, maddr, mdata_w, ld_en, ld_sel, ld_addr, ld_data,
           start, x_valid, x_data,
    output ready, idata, mdata_r, x_ready, o_valid, o_t, o_h, o_data, done
  );
  modport master (
    output busy, i_en, mce, msel, maddr, mdata_w, ld_en, ld_sel, ld_addr, ld_data,
           start, x_valid, x_data,
    input  ready, idata, mdata_r, x_ready, o_valid, o_t, o_h, o_data, done
  );
endinterface

// File: rtl/rnn_mem_responder_xfifo.sv
// Synchronous input-vector FIFO; head reads as zero while empty.
module rnn_xfifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = o_empty ? '0 : r_mem[r_rd];
  assign o_count = r_cnt;

  always_ff @(posedge clk) if (w_push) r_mem[r_wr] <= i_data;

  // Pointers are PW bits wide, so wrap modulo DEPTH falls out of overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/rnn_mem_responder.sv
// Far-end memory/input responder for the RNN core. Optional error flag: RNN_MEM_ERR_EN.
module rnn_mem_responder #(
  parameter int H_DIM      = rnn_mem_pkg::H_DIM,
  parameter int X_DIM      = rnn_mem_pkg::X_DIM,
  parameter int DW         = rnn_mem_pkg::DW,
  parameter int TW         = rnn_mem_pkg::TW,
  parameter int FIFO_DEPTH = rnn_mem_pkg::FIFO_DEPTH
) (
  input logic clk,
  input logic reset,
  rnn_mem_responder_if.slave bus
`ifdef RNN_MEM_ERR_EN
  , output logic o_err
`endif
);
  import rnn_mem_pkg::*;

  localparam int HW = $clog2(H_DIM);
  localparam int XW = $clog2(X_DIM);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DW-1:0] r_wih [H_DIM*X_DIM];
  logic [DW-1:0] r_bih [H_DIM];
  logic [DW-1:0] r_whh [H_DIM*H_DIM];
  logic [DW-1:0] r_bhh [H_DIM];

  logic [TW-1:0] r_t;
  logic [DW-1:0] r_mdata, r_o_data;
  logic [TW-1:0] r_o_t;
  logic [5:0]    r_o_h;
  logic          r_o_valid, r_done, r_ready, r_x_ready;
  run_state_t    r_state, w_state_nxt;

  logic          w_ld_ok, w_wr, w_last, w_push, w_pop, w_full, w_empty;
  logic [CW-1:0] w_cnt, w_cnt_nxt;
  logic [TW-1:0] w_wt;

  assign w_ld_ok = bus.ld_en && !bus.busy && (r_state == IDLE);
  assign w_wr    = bus.mce && (bus.msel == MSEL_OUT);
  assign w_wt    = bus.maddr[HW +: TW];
  assign w_last  = (w_wt == r_t - TW'(1)) && (bus.maddr[HW-1:0] == HW'(H_DIM-1));

  // Bank contents are deliberately not reset so a host load survives an abort.
  always_ff @(posedge clk) begin
    if (w_ld_ok) begin
      case (bus.ld_sel)
        MSEL_WIH: r_wih[bus.ld_addr[HW+XW-1:0]] <= bus.ld_data;
        MSEL_BIH: r_bih[bus.ld_addr[HW-1:0]]    <= bus.ld_data;
        MSEL_WHH: r_whh[bus.ld_addr[2*HW-1:0]]  <= bus.ld_data;
        MSEL_BHH: r_bhh[bus.ld_addr[HW-1:0]]    <= bus.ld_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_t       <= '0;
      r_mdata   <= '0;
      r_o_valid <= 1'b0;
      r_o_t     <= '0;
      r_o_h     <= '0;
      r_o_data  <= '0;
      r_done    <= 1'b0;
    end else begin
      if (w_ld_ok && bus.ld_sel == MSEL_T) r_t <= bus.ld_data[TW-1:0];
      case (bus.msel)
        MSEL_WIH: r_mdata <= r_wih[bus.maddr[HW+XW-1:0]];
        MSEL_BIH: r_mdata <= r_bih[bus.maddr[HW-1:0]];
        MSEL_WHH: r_mdata <= r_whh[bus.maddr[2*HW-1:0]];
        MSEL_BHH: r_mdata <= r_bhh[bus.maddr[HW-1:0]];
        MSEL_T:   r_mdata <= DW'(r_t);
        default:  r_mdata <= '0;
      endcase
      r_o_valid <= w_wr;
      r_done    <= w_wr && w_last;
      if (w_wr) begin
        r_o_t    <= w_wt;
        r_o_h    <= bus.maddr[5:0];
        r_o_data <= bus.mdata_w;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = ARMED;
      ARMED:   if (bus.busy) w_state_nxt = RUN;
      RUN:     if (r_done || !bus.busy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_push    = bus.x_valid && r_x_ready && !w_full;
  assign w_pop     = bus.i_en && !w_empty;
  assign w_cnt_nxt = w_cnt + CW'(w_push) - CW'(w_pop);

  // ready/x_ready are registered from next-cycle state so they line up with the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ready   <= 1'b0;
      r_x_ready <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ready   <= (w_state_nxt == ARMED) && (w_cnt_nxt != '0);
      r_x_ready <= (w_cnt_nxt != CW'(FIFO_DEPTH));
    end
  end

  rnn_xfifo #(.W(X_DIM), .DEPTH(FIFO_DEPTH)) u_xfifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (bus.i_en),
    .i_data  (bus.x_data),
    .o_head  (bus.idata),
    .o_count (w_cnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.mdata_r = r_mdata;
  assign bus.ready   = r_ready;
  assign bus.x_ready = r_x_ready;
  assign bus.o_valid = r_o_valid;
  assign bus.o_t     = r_o_t;
  assign bus.o_h     = r_o_h;
  assign bus.o_data  = r_o_data;
  assign bus.done    = r_done;

`ifdef RNN_MEM_ERR_EN
  logic r_err, r_busy_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err    <= 1'b0;
      r_busy_d <= 1'b0;
    end else begin
      r_busy_d <= bus.busy;
      if ((bus.i_en && w_empty) ||
          (bus.mce && bus.msel != MSEL_OUT) ||
          (w_wr && w_wt >= r_t) ||
          (bus.busy && !r_busy_d && w_empty))
        r_err <= 1'b1;
    end
  end
  assign o_err = r_err;
`endif
endmodule
